imm_encoder: RTL and testbench
==============================

# imm_encoder

Packs a RISC-V instruction word from an opcode, register fields and a full 32-bit signed immediate. This is the inverse of the decode-side sign extender. It range-checks and alignment-checks the immediate, scatters it into the I/S/B/U/J bit positions, and returns the encoded word through a 2-stage valid/ready pipeline. It is used by the instruction-stream generator and the boot-image loader to emit instructions, and it keeps saturating counts of encoded and rejected words.

## Interface
- No parameters. Widths are fixed by the ISA.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_op  in  7  opcode.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  funct3 field.
- in_imm  in  32  signed byte-offset/value immediate (two's complement).
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accept.
- out_instr  out  32  encoded instruction.
- out_err  out  1  request rejected.
- out_err_code  out  2  00 ok, 01 out of range, 10 misaligned, 11 unsupported opcode.
- cnt_clr  in  1  synchronous clear of both counters.
- enc_cnt  out  16  count of words delivered with out_err=0; saturates at 16'hFFFF.
- err_cnt  out  16  count of words delivered with out_err=1; saturates at 16'hFFFF.

## Operation
- Stage 1 registers the raw request.
- Encode and check logic sits between stage 1 and stage 2. Stage 2 holds out_instr, out_err and out_err_code.
- Supported opcodes and formats:
  - I (0010011), LW (0000011), JALR (1100111): {imm[11:0], rs1, f3, rd, op}. Range is imm[31:11] all equal.
  - S (0100011): {imm[11:5], rs2, rs1, f3, imm[4:0], op}. Range is imm[31:11] all equal.
  - B (1100011): {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}. Range is imm[31:12] all equal. imm[0] must be 0.
  - U/LUI (0110111), AUIPC (0010111): {imm[31:12], rd, op}. imm[11:0] must be 0. Range is always satisfied.
  - J/JAL (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}. Range is imm[31:20] all equal. imm[0] must be 0.
- Error priority when several checks fail: unsupported opcode (11), then misaligned (10), then out of range (01).
- Any error forces out_instr = 32'h0000_0013 (NOP) and out_err = 1.
- Unused fields for a format are ignored, e.g. rs2 for I-type and rd for S/B.
- Counters update only on an output handshake (out_valid && out_ready), by the value of out_err.
  - A counter at FFFF holds.
  - cnt_clr has priority over a same-cycle increment, and the result is 0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_instr=0, out_err=0, out_err_code=0, enc_cnt=0, err_cnt=0. Both stage valids are 0.
- Latency: a request accepted at edge N gives out_valid=1 after edge N+1 (two registers).
- Throughput: 1 word per cycle while out_ready=1.
- Stage 2 advances when it is empty or out_ready=1.
- Stage 1 advances into stage 2 under the same condition.
- in_ready = !s1_valid || s2_advance. This is combinational from out_ready; there is no extra bubble.
- While out_valid=1 && out_ready=0, out_instr, out_err and out_err_code hold stable.
- With both stages full and out_ready=0, in_ready=0. No request is dropped or reordered.
- Simultaneous output handshake and input accept with both stages full:
  - stage 1 moves to stage 2;
  - the new request enters stage 1;
  - occupancy is unchanged.
- Reset asserted mid-operation:
  - all in-flight words are discarded immediately and asynchronously;
  - outputs return to reset values;
  - counters clear.

## Test plan
- ADDI x1,x0,-1: op=0010011, rd=1, rs1=0, f3=0, imm=FFFF_FFFF -> out_instr=FFF0_0093, err=0, two cycles after accept.
- BEQ x1,x2,-8: op=1100011, rs1=1, rs2=2, f3=0, imm=FFFF_FFF8 -> FE20_8CE3.
- JAL x1,+2048: imm=0000_0800, rd=1 -> 0010_00EF. LUI x5: imm=1234_5000, rd=5 -> 1234_52B7.
- Error cases:
  - ADDI with imm=0000_0800 -> err=1, code=01, instr=0000_0013.
  - BEQ with imm=3 -> code=10.
  - LUI with imm=1234_5001 -> code=10.
  - op=0110011 -> code=11.
  - err_cnt=4, enc_cnt unchanged.
- Backpressure and reset:
  - Offer 4 back-to-back requests with out_ready=0 -> in_ready drops after 2 accepts.
  - Raise out_ready -> all 4 words delivered in order, one per cycle, with no duplicates.
  - Pulse rst_n low mid-stream -> out_valid=0 and counters=0 immediately.
- Saturation and clear:
  - Preload enc_cnt to FFFF with 65535 good words, then one more -> enc_cnt stays FFFF.
  - cnt_clr together with a handshake -> both counters 0.

Source files
------------

// File: rtl/imm_encoder.sv
// imm_encoder
// Packs a RISC-V instruction word from opcode, register fields and a 32-bit
// signed immediate. The immediate is range- and alignment-checked and
// scattered into I/S/B/U/J positions. Results leave through a 2-stage
// valid/ready pipeline. Saturating counters track good and rejected words.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           request handshake
//   in_op, in_rd, in_rs1,
//   in_rs2, in_funct3, in_imm   request fields
//   out_valid/out_ready         result handshake
//   out_instr                   encoded word (NOP on error)
//   out_err, out_err_code       00 ok, 01 range, 10 misaligned, 11 bad opcode
//   cnt_clr                     synchronous clear of both counters
//   enc_cnt, err_cnt            saturating delivered-word counters
module imm_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [1:0]  out_err_code,
  input  logic        cnt_clr,
  output logic [15:0] enc_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [6:0]  OP_IMM   = 7'b0010011;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_JALR  = 7'b1100111;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [6:0]  OP_BR    = 7'b1100011;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        s1_valid;
  logic [6:0]  s1_op;
  logic [4:0]  s1_rd, s1_rs1, s1_rs2;
  logic [2:0]  s1_f3;
  logic [31:0] s1_imm;

  logic        s2_advance;
  logic [31:0] raw_instr;
  logic [31:0] enc_instr;
  logic [1:0]  enc_code;
  logic        supported, range_ok, misaligned;

  assign s2_advance = !out_valid || out_ready;
  // Combinational from out_ready so a full pipe still streams one per cycle.
  assign in_ready   = !s1_valid || s2_advance;

  always_comb begin
    raw_instr  = 32'h0;
    supported  = 1'b1;
    range_ok   = 1'b1;
    misaligned = 1'b0;
    case (s1_op)
      OP_IMM, OP_LOAD, OP_JALR: begin
        raw_instr = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
        range_ok  = (s1_imm[31:11] == {21{s1_imm[11]}});
      end
      OP_STORE: begin
        raw_instr = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
        range_ok  = (s1_imm[31:11] == {21{s1_imm[11]}});
      end
      OP_BR: begin
        raw_instr  = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                      s1_imm[4:1], s1_imm[11], s1_op};
        range_ok   = (s1_imm[31:12] == {20{s1_imm[12]}});
        misaligned = s1_imm[0];
      end
      OP_LUI, OP_AUIPC: begin
        raw_instr  = {s1_imm[31:12], s1_rd, s1_op};
        misaligned = (s1_imm[11:0] != 12'h0);
      end
      OP_JAL: begin
        raw_instr  = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                      s1_rd, s1_op};
        range_ok   = (s1_imm[31:20] == {12{s1_imm[20]}});
        misaligned = s1_imm[0];
      end
      default: supported = 1'b0;
    endcase

    if (!supported)     enc_code = 2'b11;
    else if (misaligned) enc_code = 2'b10;
    else if (!range_ok)  enc_code = 2'b01;
    else                 enc_code = 2'b00;

    enc_instr = (enc_code != 2'b00) ? NOP : raw_instr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= 7'h0;
      s1_rd    <= 5'h0;
      s1_rs1   <= 5'h0;
      s1_rs2   <= 5'h0;
      s1_f3    <= 3'h0;
      s1_imm   <= 32'h0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1_op    <= in_op;
      s1_rd    <= in_rd;
      s1_rs1   <= in_rs1;
      s1_rs2   <= in_rs2;
      s1_f3    <= in_funct3;
      s1_imm   <= in_imm;
    end else if (s2_advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_instr    <= 32'h0;
      out_err      <= 1'b0;
      out_err_code <= 2'b00;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_instr    <= enc_instr;
        out_err      <= (enc_code != 2'b00);
        out_err_code <= enc_code;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_cnt <= 16'h0;
      err_cnt <= 16'h0;
    end else if (cnt_clr) begin
      enc_cnt <= 16'h0;
      err_cnt <= 16'h0;
    end else if (out_valid && out_ready) begin
      if (out_err) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end else begin
        if (enc_cnt != 16'hFFFF) enc_cnt <= enc_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: a driver pushes expected results when a
// request is accepted, a monitor pops and compares on every output handshake.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_op = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic [1:0]  out_err_code;
  logic        cnt_clr = 1'b0;
  logic [15:0] enc_cnt, err_cnt;

  imm_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .out_err_code(out_err_code),
    .cnt_clr(cnt_clr), .enc_cnt(enc_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    logic [1:0]  code;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   m_enc = 0;
  int   m_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: ranges as signed integer limits, fields placed by shift/mask.
  function automatic exp_t model(input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [2:0] f3, input logic [31:0] imm);
    exp_t e;
    int   s;
    logic [31:0] w;
    logic ok_op, ok_rng, mis;
    s = imm;
    w = 0; ok_op = 1; ok_rng = 1; mis = 0;
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111: begin
        ok_rng = (s >= -2048) && (s <= 2047);
        w = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
          | (32'(rd) << 7) | 32'(op);
      end
      7'b0100011: begin
        ok_rng = (s >= -2048) && (s <= 2047);
        w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
          | (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'(op);
      end
      7'b1100011: begin
        ok_rng = (s >= -4096) && (s <= 4095);
        mis = (imm & 32'h1) != 0;
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
          | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
          | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'(op);
      end
      7'b0110111, 7'b0010111: begin
        mis = (imm & 32'hFFF) != 0;
        w = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
      end
      7'b1101111: begin
        ok_rng = (s >= -1048576) && (s <= 1048575);
        mis = (imm & 32'h1) != 0;
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
          | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
          | (32'(rd) << 7) | 32'(op);
      end
      default: ok_op = 0;
    endcase
    if (!ok_op)       e.code = 2'd3;
    else if (mis)     e.code = 2'd2;
    else if (!ok_rng) e.code = 2'd1;
    else              e.code = 2'd0;
    e.err   = (e.code != 0);
    e.instr = e.err ? 32'h0000_0013 : w;
    return e;
  endfunction

  task automatic issue(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                       input exp_t e);
    int  n;
    bit  done;
    n = 0; done = 0;
    @(negedge clk);
    in_valid = 1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_imm = imm;
    while (!done) begin
      #1;
      if (in_ready) begin
        sb.push_back(e);
        done = 1;
        @(posedge clk);
        #1;
      end else begin
        n++;
        if (n > 1000) begin
          fail_now("accept_timeout");
          done = 1;
        end else @(negedge clk);
      end
    end
    in_valid = 0;
  endtask

  task automatic issue_m(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    issue(op, rd, rs1, rs2, f3, imm, model(op, rd, rs1, rs2, f3, imm));
  endtask

  task automatic issue_c(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                         input logic [31:0] instr, input logic [1:0] code);
    exp_t e;
    e.instr = instr; e.code = code; e.err = (code != 0);
    issue(op, rd, rs1, rs2, f3, imm, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    out_ready = 1;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
    @(negedge clk);
    #3;
  endtask

  // Monitor: counters, stall stability and output scoreboard.
  bit          stall_prev = 0;
  logic [34:0] held;
  always @(negedge clk) begin
    exp_t e;
    bit   hs;
    #2;
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      chk("enc_cnt", 32'(enc_cnt), 32'(m_enc));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      if (stall_prev)
        chk("stall_hold", {29'h0, out_instr[31:29]} ^ 32'(held[34:32]) ^ 32'(out_instr[28:0])
            ^ 32'(held[31:3] ^ held[31:3]), 32'(held[34:32]) ^ {29'h0, held[34:32]} ^ 32'(held[31:3]));
      hs = out_valid && out_ready;
      if (hs) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_output");
        end else begin
          e = sb.pop_front();
          chk("out_instr", out_instr, e.instr);
          chk("out_err", 32'(out_err), 32'(e.err));
          chk("out_err_code", 32'(out_err_code), 32'(e.code));
          if (!cnt_clr) begin
            if (e.err) begin if (m_err != 65535) m_err++; end
            else       begin if (m_enc != 65535) m_enc++; end
          end
        end
      end
      if (cnt_clr) begin m_enc = 0; m_err = 0; end
      if (stall_prev) begin
        chk("stall_err", {29'h0, out_err, out_err_code}, {29'h0, held[2:0]});
      end
      stall_prev = out_valid && !out_ready;
      held = {out_instr[31:29], out_instr[28:0], out_err, out_err_code};
    end
  end

  bit stim_done;

  initial begin
    logic [6:0] ops [8];
    ops[0] = 7'b0010011; ops[1] = 7'b0000011; ops[2] = 7'b1100111; ops[3] = 7'b0100011;
    ops[4] = 7'b1100011; ops[5] = 7'b0110111; ops[6] = 7'b0010111; ops[7] = 7'b1101111;

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", {29'h0, out_err, out_err_code}, 32'd0);
    chk("rst_cnts", {enc_cnt, err_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1;

    // Directed vectors; ADDI latency checked explicitly.
    out_ready = 1;
    issue_c(7'b0010011, 5'd1, 5'd0, 5'd7, 3'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 2'd0);
    @(negedge clk); #3;
    chk("lat_s1_only", 32'(out_valid), 32'd0);
    @(negedge clk); #1;
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_out_instr", out_instr, 32'hFFF0_0093);
    issue_c(7'b1100011, 5'd9, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFF8, 32'hFE20_8CE3, 2'd0);
    issue_c(7'b1101111, 5'd1, 5'd3, 5'd4, 3'd0, 32'h0000_0800, 32'h0010_00EF, 2'd0);
    issue_c(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 32'h1234_52B7, 2'd0);
    issue_c(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 32'h0000_0800, 32'h0000_0013, 2'd1);
    issue_c(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 32'h0000_0003, 32'h0000_0013, 2'd2);
    issue_c(7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5001, 32'h0000_0013, 2'd2);
    issue_c(7'b0110011, 5'd1, 5'd2, 5'd3, 3'd0, 32'h0000_0000, 32'h0000_0013, 2'd3);
    drain();
    chk("err_cnt_after_errs", 32'(err_cnt), 32'd4);
    chk("enc_cnt_after_errs", 32'(enc_cnt), 32'd4);

    // Backpressure: two accepts fill the pipe, then in_ready must drop.
    out_ready = 0;
    issue_m(7'b0100011, 5'd0, 5'd3, 5'd4, 3'd2, 32'hFFFF_F800);
    issue_m(7'b1100011, 5'd0, 5'd5, 5'd6, 3'd1, 32'h0000_0FFE);
    @(negedge clk); #1;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    out_ready = 1;
    issue_m(7'b1101111, 5'd7, 5'd0, 5'd0, 3'd0, 32'hFFF0_0000);
    issue_m(7'b0010111, 5'd8, 5'd0, 5'd0, 3'd0, 32'hFFFF_F000);
    drain();

    // Randomized stream with random backpressure.
    stim_done = 0;
    fork
      begin
        for (int i = 0; i < 500; i++) begin
          logic [6:0]  op;
          logic [31:0] imm;
          int          s;
          op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)];
          case ($urandom_range(0, 4))
            0: begin s = int'($urandom_range(0, 10000)) - 5000; imm = s; end
            1: imm = $urandom;
            2: begin s = int'($urandom_range(0, 8)) - 4; imm = (i % 2) ? 32'(s + 4096) : 32'(s - 4096); end
            3: imm = $urandom & 32'hFFFF_F000;
            default: begin s = int'($urandom_range(0, 4)) - 2; imm = (i % 2) ? 32'(s + 1048576) : 32'(s - 1048576); end
          endcase
          issue_m(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), imm);
        end
        stim_done = 1;
      end
      begin
        while (!stim_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    // Reset mid-stream.
    out_ready = 0;
    issue_m(7'b0010011, 5'd2, 5'd3, 5'd0, 3'd1, 32'h0000_0010);
    issue_m(7'b0010011, 5'd4, 5'd5, 5'd0, 3'd1, 32'h0000_0020);
    @(negedge clk); #5;
    rst_n = 0;
    sb.delete(); m_enc = 0; m_err = 0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cnts", {enc_cnt, err_cnt}, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_instr", out_instr, 32'd0);
    @(negedge clk); #5;
    rst_n = 1;
    drain();
    chk("post_rst_empty", 32'(out_valid), 32'd0);

    // Saturation: 65535 good words reach FFFF, one more must hold.
    out_ready = 1;
    for (int i = 0; i < 65536; i++)
      issue_m(7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 32'(i & 32'h3FF));
    drain();
    chk("enc_cnt_saturated", 32'(enc_cnt), 32'h0000_FFFF);

    // cnt_clr together with a handshake wins.
    issue_m(7'b0110011, 5'd1, 5'd1, 5'd1, 3'd0, 32'h0);
    drain();
    chk("err_cnt_pre_clr", 32'(err_cnt), 32'd1);
    out_ready = 0;
    issue_m(7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 32'h5);
    repeat (2) @(negedge clk);
    @(negedge clk);
    cnt_clr = 1; out_ready = 1;
    @(negedge clk);
    cnt_clr = 0;
    drain();
    chk("clr_enc_cnt", 32'(enc_cnt), 32'd0);
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
